linealizador_normalizador: RTL and testbench
============================================

LINEALIZADOR_NORMALIZADOR -- requirements
Module: linealizador_normalizador

Interface
REQ-001 Parameter P, default 32, SHALL set operand/result width; IEEE-754 single precision only.
REQ-002 Parameter V_SCALE, default 32'h3D800000 (0.0625), SHALL be the FP32 normalization factor for V.
REQ-003 Parameter I_GAIN, default 32'h3E800000 (0.25), SHALL be the FP32 linearization slope for I.
REQ-004 Parameter I_OFFSET, default 32'h3F000000 (0.5), SHALL be the FP32 linearization intercept for I.
REQ-005 Port CLK, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port RST_LN_FF, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-007 Port I, input, P, SHALL be the FP32 current sample.
REQ-008 Port V, input, P, SHALL be the FP32 voltage sample.
REQ-009 Port Begin_FSM_I, input, 1, SHALL be the start strobe for the I channel.
REQ-010 Port Begin_FSM_V, input, 1, SHALL be the start strobe for the V channel.
REQ-011 Port ACK_I, output, 1, SHALL flag RESULT_I valid.
REQ-012 Port ACK_V, output, 1, SHALL flag RESULT_V valid.
REQ-013 Port RESULT_I, output, 32, SHALL be the registered FP32 I result.
REQ-014 Port RESULT_V, output, 32, SHALL be the registered FP32 V result.

Function
REQ-015 The V and I channels SHALL be independent FSMs; both may start on the same edge.
REQ-016 The V channel SHALL compute RESULT_V = V * V_SCALE.
REQ-017 The I channel SHALL compute RESULT_I = I * I_GAIN + I_OFFSET, with the product rounded before the add.
REQ-018 V FSM states SHALL be IDLE -> MUL -> NORM -> DONE.
REQ-019 I FSM states SHALL be IDLE -> MUL -> MNORM -> ALIGN -> ADD -> NORM -> DONE.
REQ-020 In IDLE or DONE, Begin high at an edge SHALL capture the operand, clear ACK and enter MUL.
REQ-021 In any other state, Begin SHALL be ignored.
REQ-022 ACK_V SHALL rise on the 3rd rising edge after the capturing edge; ACK_I SHALL rise on the 6th.
REQ-023 ACK and RESULT SHALL hold in DONE until reset or a new Begin.
REQ-024 RESULT SHALL update only on entry to DONE.
REQ-025 Inputs SHALL be sampled only at the capturing edge; later changes SHALL NOT affect the result.
REQ-026 Mantissa products and sums SHALL use 24-bit significands with hidden bit.
REQ-027 Rounding SHALL be toward zero (truncation) at every rounding step.
REQ-028 Zero or denormal operands (exponent 0) SHALL be treated as +-0; denormal results SHALL flush to +-0.
REQ-029 A biased exponent above 254 SHALL saturate to +-Inf (exponent 255, mantissa 0).
REQ-030 An operand with exponent 255 SHALL produce 32'h7FC00000.
REQ-031 An exact zero sum SHALL return +0 (32'h00000000).
REQ-032 Alignment SHALL shift the smaller-exponent significand right; a shift of 25 or more SHALL zero it.

Reset
REQ-033 While RST_LN_FF is low, both FSMs SHALL be in IDLE, ACK_I=ACK_V=0 and RESULT_I=RESULT_V=0, immediately and without a clock.
REQ-034 Reset asserted mid-computation SHALL abort the operation; no ACK SHALL follow the release.
REQ-035 After release, the first edge with Begin high SHALL start a fresh operation.

Verification
REQ-036 Reset low -> ACK_I=ACK_V=0, RESULT_I=RESULT_V=32'h0 with no clock edge.
REQ-037 V=32'h42C80000 (100.0), 1-cycle Begin_FSM_V -> RESULT_V=32'h40C80000 (6.25), ACK_V high 3 edges later and held.
REQ-038 I=32'h40000000 (2.0), Begin_FSM_I -> RESULT_I=32'h3F800000 (1.0), ACK_I high 6 edges later.
REQ-039 I=32'hC0000000 (-2.0) -> RESULT_I=32'h00000000; I=0 -> RESULT_I=32'h3F000000.
REQ-040 Simultaneous Begins with I=0 and V=0 -> RESULT_V=0 at edge 3, RESULT_I=32'h3F000000 at edge 6, then both ACK high.
REQ-041 Begin pulsed again while busy -> ignored; reset pulsed mid-run -> ACKs stay 0 until the next Begin.

Source files
------------

// File: rtl/linealizador_normalizador.sv
// FP32 linearizer/normalizer: V channel scales V by V_SCALE; I channel computes I*I_GAIN+I_OFFSET.
// Truncating arithmetic, zero/denormal operands flushed, exponent-255 operands produce a quiet NaN.
module linealizador_normalizador #(
  parameter int          P        = 32,
  parameter logic [31:0] V_SCALE  = 32'h3D800000,
  parameter logic [31:0] I_GAIN   = 32'h3E800000,
  parameter logic [31:0] I_OFFSET = 32'h3F000000
) (
  input  logic         CLK,
  input  logic         RST_LN_FF,
  input  logic [P-1:0] I,
  input  logic [P-1:0] V,
  input  logic         Begin_FSM_I,
  input  logic         Begin_FSM_V,
  output logic         ACK_I,
  output logic         ACK_V,
  output logic [31:0]  RESULT_I,
  output logic [31:0]  RESULT_V
);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam logic [1:0] V_IDLE = 2'd0, V_MUL = 2'd1, V_NORM = 2'd2, V_DONE = 2'd3;
  localparam logic [2:0] I_IDLE = 3'd0, I_MUL = 3'd1, I_MNORM = 3'd2, I_ALIGN = 3'd3,
                         I_ADD  = 3'd4, I_NORM = 3'd5, I_DONE = 3'd6;

  function automatic logic [31:0] fp_pack(input logic s, input logic signed [10:0] e,
                                          input logic [22:0] m);
    logic [31:0] r;
    if (e <= 11'sd0)        r = {s, 31'd0};
    else if (e > 11'sd254)  r = {s, 8'hFF, 23'd0};
    else                    r = {s, e[7:0], m};
    return r;
  endfunction

  function automatic logic [31:0] mul_norm(input logic s, input logic signed [10:0] e,
                                           input logic z, input logic n, input logic [47:0] pr);
    logic [31:0] r;
    if (n)           r = QNAN;
    else if (z)      r = {s, 31'd0};
    else if (pr[47]) r = fp_pack(s, e + 11'sd1, pr[46:24]);
    else             r = fp_pack(s, e, pr[45:23]);
    return r;
  endfunction

  function automatic logic [4:0] lzc24(input logic [23:0] x);
    logic [4:0] r;
    r = 5'd24;
    for (int k = 0; k < 24; k++)
      if (x[k]) r = 5'(23 - k);
    return r;
  endfunction

  function automatic logic [31:0] add_norm(input logic s, input logic [7:0] e, input logic n,
                                           input logic [24:0] sum);
    logic [4:0]  lz;
    logic [23:0] sh;
    logic [31:0] r;
    lz = lzc24(sum[23:0]);
    sh = sum[23:0] << lz;
    if (n)                r = QNAN;
    else if (sum == '0)   r = 32'd0;
    else if (sum[24])     r = fp_pack(s, $signed({3'b0, e}) + 11'sd1, sum[23:1]);
    else                  r = fp_pack(s, $signed({3'b0, e}) - $signed({6'b0, lz}), sh[22:0]);
    return r;
  endfunction

  // Two-cycle multipliers: cycle 1 registers two 24x12 partial products, cycle 2 sums them.
  logic [31:0] mul_a [2];
  logic [31:0] mul_r [2];
  logic [1:0]  pp_en, sum_en;

  for (genvar g = 0; g < 2; g++) begin : g_mul
    localparam logic [31:0] K  = (g == 0) ? V_SCALE : I_GAIN;
    localparam logic [23:0] MK = {1'b1, K[22:0]};
    logic [23:0]        ma;
    logic [35:0]        pp_lo_q, pp_hi_q;
    logic [47:0]        prod_q;
    logic               s_q, z_q, n_q;
    logic signed [10:0] e_q;

    assign ma = {1'b1, mul_a[g][22:0]};

    always_ff @(posedge CLK or negedge RST_LN_FF) begin
      if (!RST_LN_FF) begin
        pp_lo_q <= '0; pp_hi_q <= '0; prod_q <= '0;
        s_q <= 1'b0; z_q <= 1'b0; n_q <= 1'b0; e_q <= '0;
      end else begin
        if (pp_en[g]) begin
          pp_lo_q <= {12'd0, ma} * {24'd0, MK[11:0]};
          pp_hi_q <= {12'd0, ma} * {24'd0, MK[23:12]};
          s_q     <= mul_a[g][31] ^ K[31];
          e_q     <= $signed({3'b0, mul_a[g][30:23]}) + $signed({3'b0, K[30:23]}) - 11'sd127;
          z_q     <= (mul_a[g][30:23] == 8'h00) || (K[30:23] == 8'h00);
          n_q     <= (mul_a[g][30:23] == 8'hFF) || (K[30:23] == 8'hFF);
        end
        if (sum_en[g]) prod_q <= {12'd0, pp_lo_q} + {pp_hi_q, 12'd0};
      end
    end

    assign mul_r[g] = mul_norm(s_q, e_q, z_q, n_q, prod_q);
  end

  // V channel
  logic [1:0]  v_st_q;
  logic        v_ph_q;
  logic [31:0] v_op_q;

  assign mul_a[0]  = v_op_q;
  assign pp_en[0]  = (v_st_q == V_MUL) && !v_ph_q;
  assign sum_en[0] = (v_st_q == V_MUL) && v_ph_q;

  always_ff @(posedge CLK or negedge RST_LN_FF) begin
    if (!RST_LN_FF) begin
      v_st_q <= V_IDLE; v_ph_q <= 1'b0; v_op_q <= '0; ACK_V <= 1'b0; RESULT_V <= '0;
    end else begin
      case (v_st_q)
        V_IDLE, V_DONE: if (Begin_FSM_V) begin
          v_op_q <= V; ACK_V <= 1'b0; v_ph_q <= 1'b0; v_st_q <= V_MUL;
        end
        V_MUL: begin
          v_ph_q <= 1'b1;
          if (v_ph_q) v_st_q <= V_NORM;
        end
        V_NORM: begin
          RESULT_V <= mul_r[0]; ACK_V <= 1'b1; v_st_q <= V_DONE;
        end
        default: v_st_q <= V_IDLE;
      endcase
    end
  end

  // I channel
  logic [2:0]  i_st_q;
  logic        i_ph_q;
  logic [31:0] i_op_q, p_q;
  logic [7:0]  al_el_q;
  logic [23:0] al_ml_q, al_ms_q;
  logic        al_s_q, al_sub_q, al_nan_q;
  logic [24:0] ad_sum_q;
  logic [7:0]  ad_e_q;
  logic        ad_s_q, ad_nan_q;

  assign mul_a[1]  = i_op_q;
  assign pp_en[1]  = (i_st_q == I_MUL) && !i_ph_q;
  assign sum_en[1] = (i_st_q == I_MUL) && i_ph_q;

  // Larger magnitude goes first so the ADD stage never produces a negative difference.
  logic [7:0]  ea, eb, el, es, d;
  logic [23:0] ma, mb, ml, ms, ms_al;
  logic        swap, sl, ss, al_nan;

  always_comb begin
    ea     = p_q[30:23];
    eb     = I_OFFSET[30:23];
    ma     = (ea == 8'h00) ? 24'd0 : {1'b1, p_q[22:0]};
    mb     = (eb == 8'h00) ? 24'd0 : {1'b1, I_OFFSET[22:0]};
    swap   = (eb > ea) || ((eb == ea) && (mb > ma));
    el     = swap ? eb : ea;
    es     = swap ? ea : eb;
    ml     = swap ? mb : ma;
    ms     = swap ? ma : mb;
    sl     = swap ? I_OFFSET[31] : p_q[31];
    ss     = swap ? p_q[31] : I_OFFSET[31];
    d      = el - es;
    ms_al  = (d >= 8'd25) ? 24'd0 : (ms >> d);
    al_nan = (ea == 8'hFF) || (eb == 8'hFF);
  end

  always_ff @(posedge CLK or negedge RST_LN_FF) begin
    if (!RST_LN_FF) begin
      i_st_q <= I_IDLE; i_ph_q <= 1'b0; i_op_q <= '0; ACK_I <= 1'b0; RESULT_I <= '0;
      p_q <= '0; al_el_q <= '0; al_ml_q <= '0; al_ms_q <= '0;
      al_s_q <= 1'b0; al_sub_q <= 1'b0; al_nan_q <= 1'b0;
      ad_sum_q <= '0; ad_e_q <= '0; ad_s_q <= 1'b0; ad_nan_q <= 1'b0;
    end else begin
      case (i_st_q)
        I_IDLE, I_DONE: if (Begin_FSM_I) begin
          i_op_q <= I; ACK_I <= 1'b0; i_ph_q <= 1'b0; i_st_q <= I_MUL;
        end
        I_MUL: begin
          i_ph_q <= 1'b1;
          if (i_ph_q) i_st_q <= I_MNORM;
        end
        I_MNORM: begin
          p_q <= mul_r[1]; i_st_q <= I_ALIGN;
        end
        I_ALIGN: begin
          al_el_q <= el; al_ml_q <= ml; al_ms_q <= ms_al;
          al_s_q <= sl; al_sub_q <= sl ^ ss; al_nan_q <= al_nan;
          i_st_q <= I_ADD;
        end
        I_ADD: begin
          ad_sum_q <= al_sub_q ? ({1'b0, al_ml_q} - {1'b0, al_ms_q})
                               : ({1'b0, al_ml_q} + {1'b0, al_ms_q});
          ad_s_q <= al_s_q; ad_e_q <= al_el_q; ad_nan_q <= al_nan_q;
          i_st_q <= I_NORM;
        end
        I_NORM: begin
          RESULT_I <= add_norm(ad_s_q, ad_e_q, ad_nan_q, ad_sum_q);
          ACK_I    <= 1'b1;
          i_st_q   <= I_DONE;
        end
        default: i_st_q <= I_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_linealizador_normalizador.sv
// Bench for linealizador_normalizador: directed cases plus randomized runs against a real-valued model.
module tb_linealizador_normalizador;
  localparam logic [31:0] VS = 32'h3D800000, IG = 32'h3E800000, IO = 32'h3F000000;
  localparam logic [31:0] QN = 32'h7FC00000;

  logic        CLK = 1'b0, RST_LN_FF = 1'b1;
  logic [31:0] I = '0, V = '0;
  logic        Begin_FSM_I = 1'b0, Begin_FSM_V = 1'b0;
  logic        ACK_I, ACK_V;
  logic [31:0] RESULT_I, RESULT_V;

  int vectors = 0, miscompares = 0;
  logic [31:0] pv = '0, pi = '0;
  logic        av = 1'b0, ai = 1'b0;

  linealizador_normalizador #(.P(32), .V_SCALE(VS), .I_GAIN(IG), .I_OFFSET(IO)) dut (
    .CLK(CLK), .RST_LN_FF(RST_LN_FF), .I(I), .V(V),
    .Begin_FSM_I(Begin_FSM_I), .Begin_FSM_V(Begin_FSM_V),
    .ACK_I(ACK_I), .ACK_V(ACK_V), .RESULT_I(RESULT_I), .RESULT_V(RESULT_V));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Magnitude of an FP32 value as a real; exponent 0 reads as zero.
  function automatic real f2r(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0.0;
    return $bitstoreal({1'b0, 11'(int'(x[30:23]) + 896), x[22:0], 29'd0});
  endfunction

  // Truncate a non-negative real to FP32 with flush-to-zero and saturation.
  function automatic logic [31:0] r2f(input logic s, input real mag);
    logic [63:0] b;
    int e;
    if (mag == 0.0) return {s, 31'd0};
    b = $realtobits(mag);
    e = int'(b[62:52]) - 896;
    if (e <= 0)   return {s, 31'd0};
    if (e > 254)  return {s, 8'hFF, 23'd0};
    return {s, 8'(e), b[51:29]};
  endfunction

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] k);
    if (a[30:23] == 8'hFF || k[30:23] == 8'hFF) return QN;
    return r2f(a[31] ^ k[31], f2r(a) * f2r(k));
  endfunction

  function automatic real trunc_to(input real x, input real u);
    real m;
    m = (x < 0.0) ? -x : x;
    m = $floor(m / u) * u;
    return (x < 0.0) ? -m : m;
  endfunction

  // Sum with the smaller-exponent operand truncated to the larger operand's ulp grid.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    real va, vb, ul, sum;
    int ea, eb, el;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QN;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    va = a[31] ? -f2r(a) : f2r(a);
    vb = b[31] ? -f2r(b) : f2r(b);
    el = (ea >= eb) ? ea : eb;
    if (el == 0) return 32'd0;
    ul = $bitstoreal({1'b0, 11'(el + 873), 52'd0});
    if (ea >= eb) vb = trunc_to(vb, ul);
    else          va = trunc_to(va, ul);
    sum = va + vb;
    if (sum == 0.0) return 32'd0;
    return r2f(sum < 0.0, (sum < 0.0) ? -sum : sum);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       ;
      1:       r[30:23] = 8'h00;
      2:       r[30:23] = 8'hFF;
      3:       r[30:23] = 8'($urandom_range(1, 4));
      4:       r[30:23] = 8'($urandom_range(250, 254));
      default: r[30:23] = 8'($urandom_range(125, 130));
    endcase
    return r;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_ack_v"}, 32'(ACK_V), 32'(av));
    chk({tag, "_res_v"}, RESULT_V, pv);
    chk({tag, "_ack_i"}, 32'(ACK_I), 32'(ai));
    chk({tag, "_res_i"}, RESULT_I, pi);
  endtask

  // Launch one operation on the selected channels and check all outputs every cycle until done.
  task automatic run(input logic en_v, input logic en_i, input logic [31:0] vv,
                     input logic [31:0] vi, input logic poke);
    logic [31:0] xv, xi;
    int last;
    xv   = model_mul(vv, VS);
    xi   = model_add(model_mul(vi, IG), IO);
    last = en_i ? 6 : 3;
    @(negedge CLK);
    V = vv; I = vi; Begin_FSM_V = en_v; Begin_FSM_I = en_i;
    if (en_v) av = 1'b0;
    if (en_i) ai = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge CLK);
      Begin_FSM_V = poke && en_v && (k == 2);
      Begin_FSM_I = poke && en_i && (k == 2);
      V = $urandom; I = $urandom;
      @(posedge CLK); #1;
      if (en_v && k == 3) begin pv = xv; av = 1'b1; end
      if (en_i && k == 6) begin pi = xi; ai = 1'b1; end
      chk_all($sformatf("run_c%0d", k));
    end
    Begin_FSM_V = 1'b0; Begin_FSM_I = 1'b0;
  endtask

  initial begin
    #2 RST_LN_FF = 1'b0;
    #1 chk_all("reset_noclk");
    @(negedge CLK); RST_LN_FF = 1'b1;

    run(1'b1, 1'b0, 32'h42C80000, 32'h0, 1'b0);
    chk("v_100", RESULT_V, 32'h40C80000);
    repeat (4) @(posedge CLK);
    #1 chk_all("hold");

    run(1'b0, 1'b1, 32'h0, 32'h40000000, 1'b0);
    chk("i_2", RESULT_I, 32'h3F800000);
    run(1'b0, 1'b1, 32'h0, 32'hC0000000, 1'b0);
    chk("i_m2", RESULT_I, 32'h00000000);
    run(1'b0, 1'b1, 32'h0, 32'h00000000, 1'b0);
    chk("i_0", RESULT_I, 32'h3F000000);
    run(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    chk("both_v", RESULT_V, 32'h00000000);
    chk("both_i", RESULT_I, 32'h3F000000);
    run(1'b1, 1'b1, 32'h42C80000, 32'h40000000, 1'b1);
    chk("poke_v", RESULT_V, 32'h40C80000);
    chk("poke_i", RESULT_I, 32'h3F800000);
    run(1'b0, 1'b1, 32'h0, 32'h7F800000, 1'b0);
    chk("i_inf", RESULT_I, QN);

    // Abort mid-run with an asynchronous reset.
    @(negedge CLK);
    V = $urandom; I = $urandom; Begin_FSM_V = 1'b1; Begin_FSM_I = 1'b1;
    @(negedge CLK);
    Begin_FSM_V = 1'b0; Begin_FSM_I = 1'b0;
    @(posedge CLK); #2 RST_LN_FF = 1'b0;
    pv = '0; pi = '0; av = 1'b0; ai = 1'b0;
    #1 chk_all("rst_mid");
    @(negedge CLK); RST_LN_FF = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      chk_all("post_rst");
    end

    for (int n = 0; n < 40; n++) begin
      logic [1:0] en;
      en = 2'($urandom_range(1, 3));
      run(en[0], en[1], rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
